// File: rtl/mc_pkg.sv
// Shared types and encodings for the multi-cycle control sequencer and its decoder.
package mc_pkg;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_FETCH  = 3'd1,
        ST_DECODE = 3'd2,
        ST_EXEC   = 3'd3,
        ST_MEM    = 3'd4,
        ST_WB     = 3'd5,
        ST_TRAP   = 3'd6
    } state_e;

    typedef enum logic [2:0] {
        CLS_R, CLS_ADDI, CLS_LW, CLS_SW, CLS_BR, CLS_JAL
    } cls_e;

    localparam logic [5:0] ALU_ADD  = 6'b000001;
    localparam logic [5:0] ALU_SUB  = 6'b000010;
    localparam logic [5:0] ALU_SLL  = 6'b000011;
    localparam logic [5:0] ALU_JAL  = 6'b000100;
    localparam logic [5:0] ALU_ADDI = 6'b000101;
    localparam logic [5:0] ALU_AND  = 6'b000110;
    localparam logic [5:0] ALU_OR   = 6'b000111;
    localparam logic [5:0] ALU_XOR  = 6'b001000;
    localparam logic [5:0] ALU_BLT  = 6'b001001;
    localparam logic [5:0] ALU_BEQ  = 6'b001010;
    localparam logic [5:0] ALU_SRL  = 6'b001011;
    localparam logic [5:0] ALU_LW   = 6'b001100;
    localparam logic [5:0] ALU_SW   = 6'b001101;

    localparam logic [6:0] OP_REG    = 7'b0110011;
    localparam logic [6:0] OP_IMM    = 7'b0010011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;

    localparam logic [2:0] F3_ADD = 3'b000;
    localparam logic [2:0] F3_SLL = 3'b001;
    localparam logic [2:0] F3_W   = 3'b010;
    localparam logic [2:0] F3_XOR = 3'b100;
    localparam logic [2:0] F3_SRL = 3'b101;
    localparam logic [2:0] F3_OR  = 3'b110;
    localparam logic [2:0] F3_AND = 3'b111;
    localparam logic [2:0] F3_BEQ = 3'b000;
    localparam logic [2:0] F3_BLT = 3'b100;

    localparam logic [6:0] F7_BASE = 7'b0000000;
    localparam logic [6:0] F7_ALT  = 7'b0100000;

    localparam logic       PC_PLUS4 = 1'b0;
    localparam logic       PC_IMM   = 1'b1;
    localparam logic       A_RS1    = 1'b0;
    localparam logic       A_PC     = 1'b1;
    localparam logic [1:0] B_RS2    = 2'b00;
    localparam logic [1:0] B_IMM    = 2'b01;
    localparam logic [1:0] B_FOUR   = 2'b10;
    localparam logic [1:0] IMM_I    = 2'b00;
    localparam logic [1:0] IMM_S    = 2'b01;
    localparam logic [1:0] IMM_B    = 2'b10;
    localparam logic [1:0] IMM_J    = 2'b11;
    localparam logic [1:0] WB_ALU   = 2'b00;
    localparam logic [1:0] WB_MEM   = 2'b01;
    localparam logic [1:0] WB_PC4   = 2'b10;

    function automatic logic [1:0] b_sel_of(cls_e c);
        case (c)
            CLS_ADDI, CLS_LW, CLS_SW: return B_IMM;
            CLS_JAL:                  return B_FOUR;
            default:                  return B_RS2;
        endcase
    endfunction

    function automatic logic [1:0] wb_sel_of(cls_e c);
        case (c)
            CLS_LW:  return WB_MEM;
            CLS_JAL: return WB_PC4;
            default: return WB_ALU;
        endcase
    endfunction

endpackage

// File: rtl/mc_control_if.sv
// Control-path bundle between the sequencer (master) and the memory/ALU/regfile datapath (slave).
interface mc_control_if;
    logic [31:0] instr;
    logic        imem_ack;
    logic        dmem_ack;
    logic        alu_zero;
    logic        alu_lt;
    logic        imem_req;
    logic        dmem_req;
    logic        dmem_we;
    logic        ir_we;
    logic        pc_we;
    logic        pc_sel;
    logic [5:0]  alu_op;
    logic        alu_a_sel;
    logic [1:0]  alu_b_sel;
    logic [1:0]  imm_sel;
    logic        rf_we;
    logic [1:0]  wb_sel;
    logic        retire;
    logic        illegal;
    logic        timeout;
    logic [2:0]  state;

    modport master (
        input  instr, imem_ack, dmem_ack, alu_zero, alu_lt,
        output imem_req, dmem_req, dmem_we, ir_we, pc_we, pc_sel, alu_op, alu_a_sel,
               alu_b_sel, imm_sel, rf_we, wb_sel, retire, illegal, timeout, state
    );

    modport slave (
        output instr, imem_ack, dmem_ack, alu_zero, alu_lt,
        input  imem_req, dmem_req, dmem_we, ir_we, pc_we, pc_sel, alu_op, alu_a_sel,
               alu_b_sel, imm_sel, rf_we, wb_sel, retire, illegal, timeout, state
    );
endinterface

// File: rtl/mc_decode.sv
// Instruction decoder: opcode/funct fields to ALU opcode, instruction class, immediate format.
// Latency: purely combinational, zero cycles.
// Backpressure: none; output is consumed whenever the sequencer sits in DECODE.
module mc_decode
    import mc_pkg::*;
(
    input  logic [6:0] opcode,
    input  logic [2:0] funct3,
    input  logic [6:0] funct7,
    output logic [5:0] alu_op,
    output cls_e       cls,
    output logic [1:0] imm_sel,
    output logic       illegal
);

    always_comb begin
        alu_op  = '0;
        cls     = CLS_R;
        imm_sel = IMM_I;
        illegal = 1'b0;
        case (opcode)
            OP_REG: begin
                case (funct3)
                    F3_ADD: begin
                        if (funct7 == F7_BASE)     alu_op = ALU_ADD;
                        else if (funct7 == F7_ALT) alu_op = ALU_SUB;
                        else                       illegal = 1'b1;
                    end
                    F3_SLL: alu_op = ALU_SLL;
                    F3_SRL: begin
                        if (funct7 == F7_BASE) alu_op = ALU_SRL;
                        else                   illegal = 1'b1;
                    end
                    F3_XOR:  alu_op = ALU_XOR;
                    F3_OR:   alu_op = ALU_OR;
                    F3_AND:  alu_op = ALU_AND;
                    default: illegal = 1'b1;
                endcase
            end
            OP_IMM: begin
                cls = CLS_ADDI;
                if (funct3 == F3_ADD) alu_op = ALU_ADDI;
                else                  illegal = 1'b1;
            end
            OP_LOAD: begin
                cls = CLS_LW;
                if (funct3 == F3_W) alu_op = ALU_LW;
                else                illegal = 1'b1;
            end
            OP_STORE: begin
                cls     = CLS_SW;
                imm_sel = IMM_S;
                if (funct3 == F3_W) alu_op = ALU_SW;
                else                illegal = 1'b1;
            end
            OP_BRANCH: begin
                cls     = CLS_BR;
                imm_sel = IMM_B;
                if (funct3 == F3_BEQ)      alu_op = ALU_BEQ;
                else if (funct3 == F3_BLT) alu_op = ALU_BLT;
                else                       illegal = 1'b1;
            end
            OP_JAL: begin
                cls     = CLS_JAL;
                imm_sel = IMM_J;
                alu_op  = ALU_JAL;
            end
            default: illegal = 1'b1;
        endcase
    end

endmodule

// File: rtl/mc_control.sv
// Multi-cycle sequencer driving fetch, decode, ALU selects, memory strobes, writeback and PC update.
// Latency: branch 3, R-type/addi/jal/sw 4, lw 5 cycles with zero-wait acks; +1 per ack wait cycle.
// Backpressure: req held until ack; missing ack for MEM_TIMEOUT cycles traps with sticky timeout.
module mc_control
    import mc_pkg::*;
#(
    parameter int MEM_TIMEOUT = 15
) (
    input  logic         clk,
    input  logic         rst_n,
    mc_control_if.master bus
);

    localparam int             CW       = (MEM_TIMEOUT > 1) ? $clog2(MEM_TIMEOUT) : 1;
    localparam logic [CW-1:0]  CNT_LAST = CW'(MEM_TIMEOUT - 1);

    state_e        st;
    cls_e          cls_q;
    logic [5:0]    alu_op_q;
    logic [1:0]    imm_sel_q;
    logic          illegal_q;
    logic          timeout_q;
    logic [CW-1:0] cnt;

    logic [5:0]    dec_alu_op;
    cls_e          dec_cls;
    logic [1:0]    dec_imm_sel;
    logic          dec_illegal;
    logic [4:0]    rd;
    logic          unused_instr;

    assign rd           = bus.instr[11:7];
    assign unused_instr = ^bus.instr[24:15];

    mc_decode u_decode (
        .opcode  (bus.instr[6:0]),
        .funct3  (bus.instr[14:12]),
        .funct7  (bus.instr[31:25]),
        .alu_op  (dec_alu_op),
        .cls     (dec_cls),
        .imm_sel (dec_imm_sel),
        .illegal (dec_illegal)
    );

    // cnt holds the number of wait cycles already spent in the current FETCH/MEM visit
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            st        <= ST_IDLE;
            cls_q     <= CLS_R;
            alu_op_q  <= '0;
            imm_sel_q <= '0;
            illegal_q <= 1'b0;
            timeout_q <= 1'b0;
            cnt       <= '0;
        end else begin
            case (st)
                ST_IDLE: begin
                    st  <= ST_FETCH;
                    cnt <= '0;
                end
                ST_FETCH: begin
                    if (bus.imem_ack) begin
                        st  <= ST_DECODE;
                        cnt <= '0;
                    end else if (cnt == CNT_LAST) begin
                        timeout_q <= 1'b1;
                        st        <= ST_TRAP;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                ST_DECODE: begin
                    alu_op_q  <= dec_alu_op;
                    imm_sel_q <= dec_imm_sel;
                    cls_q     <= dec_cls;
                    if (dec_illegal) begin
                        illegal_q <= 1'b1;
                        st        <= ST_TRAP;
                    end else begin
                        st <= ST_EXEC;
                    end
                end
                ST_EXEC: begin
                    cnt <= '0;
                    case (cls_q)
                        CLS_LW, CLS_SW: st <= ST_MEM;
                        CLS_BR:         st <= ST_FETCH;
                        default:        st <= ST_WB;
                    endcase
                end
                ST_MEM: begin
                    if (bus.dmem_ack) begin
                        st  <= (cls_q == CLS_SW) ? ST_FETCH : ST_WB;
                        cnt <= '0;
                    end else if (cnt == CNT_LAST) begin
                        timeout_q <= 1'b1;
                        st        <= ST_TRAP;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                ST_WB: begin
                    st  <= ST_FETCH;
                    cnt <= '0;
                end
                ST_TRAP: st <= ST_TRAP;
                default: st <= ST_TRAP;
            endcase
        end
    end

    always_comb begin
        bus.imem_req  = 1'b0;
        bus.dmem_req  = 1'b0;
        bus.dmem_we   = 1'b0;
        bus.ir_we     = 1'b0;
        bus.pc_we     = 1'b0;
        bus.pc_sel    = PC_PLUS4;
        bus.alu_a_sel = A_RS1;
        bus.alu_b_sel = B_RS2;
        bus.rf_we     = 1'b0;
        bus.wb_sel    = WB_ALU;
        bus.retire    = 1'b0;
        // Operand selects stay up through MEM/WB so the ALU result is stable until consumed
        if (st == ST_EXEC || st == ST_MEM || st == ST_WB) begin
            bus.alu_a_sel = (cls_q == CLS_JAL) ? A_PC : A_RS1;
            bus.alu_b_sel = b_sel_of(cls_q);
        end
        case (st)
            ST_FETCH: begin
                bus.imem_req = 1'b1;
                bus.ir_we    = bus.imem_ack;
            end
            ST_EXEC: begin
                if (cls_q == CLS_BR) begin
                    bus.pc_we  = 1'b1;
                    bus.retire = 1'b1;
                    bus.pc_sel = (alu_op_q == ALU_BEQ) ? bus.alu_zero : bus.alu_lt;
                end
            end
            ST_MEM: begin
                bus.dmem_req = 1'b1;
                bus.dmem_we  = (cls_q == CLS_SW);
                if (cls_q == CLS_SW && bus.dmem_ack) begin
                    bus.pc_we  = 1'b1;
                    bus.retire = 1'b1;
                end
            end
            ST_WB: begin
                bus.rf_we  = (rd != 5'd0);
                bus.pc_we  = 1'b1;
                bus.retire = 1'b1;
                bus.pc_sel = (cls_q == CLS_JAL) ? PC_IMM : PC_PLUS4;
                bus.wb_sel = wb_sel_of(cls_q);
            end
            default: ;
        endcase
    end

    assign bus.alu_op  = alu_op_q;
    assign bus.imm_sel = imm_sel_q;
    assign bus.illegal = illegal_q;
    assign bus.timeout = timeout_q;
    assign bus.state   = st;

endmodule

// File: tb/tb_mc_control.sv
// Bench for mc_control: randomized instruction/ack-delay stimulus against a per-instruction reference model.
module tb_mc_control;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    mc_control_if bus ();

    mc_control #(.MEM_TIMEOUT(4)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    int errors = 0;
    int checks = 0;
    int iw, dw;

    localparam int K_R = 0, K_ADDI = 1, K_LW = 2, K_SW = 3, K_BEQ = 4, K_BLT = 5, K_JAL = 6;

    localparam logic [31:0] REF_MASK [13] = '{
        32'hFE00707F, 32'hFE00707F, 32'h0000707F, 32'hFE00707F, 32'h0000707F, 32'h0000707F,
        32'h0000707F, 32'h0000707F, 32'h0000707F, 32'h0000707F, 32'h0000707F, 32'h0000707F,
        32'h0000007F};
    localparam logic [31:0] REF_MATCH [13] = '{
        32'h00000033, 32'h40000033, 32'h00001033, 32'h00005033, 32'h00004033, 32'h00006033,
        32'h00007033, 32'h00000013, 32'h00002003, 32'h00002023, 32'h00000063, 32'h00004063,
        32'h0000006F};
    localparam logic [5:0] REF_OP [13] = '{
        6'd1, 6'd2, 6'd3, 6'd11, 6'd8, 6'd7, 6'd6, 6'd5, 6'd12, 6'd13, 6'd10, 6'd9, 6'd4};
    localparam int REF_KIND [13] = '{0, 0, 0, 0, 0, 0, 0, 1, 2, 3, 4, 5, 6};

    function automatic void ref_decode(input logic [31:0] ins, output int kind, output logic [5:0] op);
        kind = -1;
        op   = '0;
        for (int i = 0; i < 13; i++)
            if ((ins & REF_MASK[i]) == REF_MATCH[i]) begin
                kind = REF_KIND[i];
                op   = REF_OP[i];
            end
    endfunction

    function automatic logic [31:0] gen_instr(input int k);
        logic [4:0]  rd, rs1, rs2;
        logic [11:0] imm;
        logic [2:0]  f3;
        logic [6:0]  f7;
        int          s;
        rd  = 5'($urandom_range(0, 31));
        rs1 = 5'($urandom_range(0, 31));
        rs2 = 5'($urandom_range(0, 31));
        imm = 12'($urandom);
        f7  = 7'h00;
        case (k)
            K_R: begin
                s = $urandom_range(0, 6);
                case (s)
                    0: f3 = 3'd0;
                    1: begin f3 = 3'd0; f7 = 7'h20; end
                    2: f3 = 3'd1;
                    3: f3 = 3'd5;
                    4: f3 = 3'd4;
                    5: f3 = 3'd6;
                    default: f3 = 3'd7;
                endcase
                return {f7, rs2, rs1, f3, rd, 7'h33};
            end
            K_ADDI:  return {imm, rs1, 3'b000, rd, 7'h13};
            K_LW:    return {imm, rs1, 3'b010, rd, 7'h03};
            K_SW:    return {imm[11:5], rs2, rs1, 3'b010, imm[4:0], 7'h23};
            K_BEQ:   return {imm[11:5], rs2, rs1, 3'b000, imm[4:0], 7'h63};
            K_BLT:   return {imm[11:5], rs2, rs1, 3'b100, imm[4:0], 7'h63};
            default: return {imm, rs1, imm[7:0], rd, 7'h6F};
        endcase
    endfunction

    // One clock: memory model acks after del wait cycles (del<0 = never); stray acks when req is low
    task automatic drive_cycle(input int idel, input int ddel, input bit z, input bit lt, input bit noise);
        @(posedge clk);
        #1;
        if (bus.imem_req) begin
            bus.imem_ack = (idel >= 0 && iw == idel);
            iw++;
        end else bus.imem_ack = noise ? 1'($urandom_range(0, 1)) : 1'b0;
        if (bus.dmem_req) begin
            bus.dmem_ack = (ddel >= 0 && dw == ddel);
            dw++;
        end else bus.dmem_ack = noise ? 1'($urandom_range(0, 1)) : 1'b0;
        bus.alu_zero = z;
        bus.alu_lt   = lt;
        @(negedge clk);
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        bus.imem_ack = 1'b0;
        bus.dmem_ack = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic run_instr(input logic [31:0] ins, input int idel, input int ddel,
                             input bit z, input bit lt, input string tag);
        int kind, ecyc, ewr, ewb, eb, ea, epc, edreq, edwe;
        logic [5:0] eop, got_op;
        int cyc, nireq, ndreq, ndwe, nrfwe, nirwe, irwe_cyc;
        logic got_pc, got_a;
        logic [1:0] got_wb, got_b;
        bit done;
        ref_decode(ins, kind, eop);
        ecyc  = (kind == K_BEQ || kind == K_BLT) ? 3 : (kind == K_LW) ? 5 : 4;
        ecyc += idel + ((kind == K_LW || kind == K_SW) ? ddel : 0);
        ewr   = (kind == K_R || kind == K_ADDI || kind == K_LW || kind == K_JAL) && (ins[11:7] != 0);
        ewb   = (kind == K_LW) ? 1 : (kind == K_JAL) ? 2 : 0;
        ea    = (kind == K_JAL);
        eb    = (kind == K_JAL) ? 2 : (kind == K_ADDI || kind == K_LW || kind == K_SW) ? 1 : 0;
        epc   = (kind == K_BEQ) ? int'(z) : (kind == K_BLT) ? int'(lt) : (kind == K_JAL) ? 1 : 0;
        edreq = (kind == K_LW || kind == K_SW) ? ddel + 1 : 0;
        edwe  = (kind == K_SW) ? ddel + 1 : 0;
        bus.instr = ins;
        iw = 0; dw = 0;
        cyc = 0; nireq = 0; ndreq = 0; ndwe = 0; nrfwe = 0; nirwe = 0; irwe_cyc = -10;
        got_op = 'x; got_pc = 1'bx; got_a = 1'bx; got_wb = 'x; got_b = 'x;
        done = 0;
        for (int n = 0; n < 40 && !done; n++) begin
            drive_cycle(idel, ddel, z, lt, 1'b1);
            if (bus.imem_req || cyc > 0) cyc++;
            if (bus.imem_req) nireq++;
            if (bus.dmem_req) ndreq++;
            if (bus.dmem_we)  ndwe++;
            if (bus.rf_we)    nrfwe++;
            if (bus.ir_we) begin nirwe++; irwe_cyc = cyc; end
            if (cyc == irwe_cyc + 2) begin got_a = bus.alu_a_sel; got_b = bus.alu_b_sel; end
            if (bus.retire) begin
                done = 1; got_op = bus.alu_op; got_pc = bus.pc_sel; got_wb = bus.wb_sel;
                checks++;
                if (bus.pc_we !== 1'b1) begin errors++; $display("FAIL %s pc_we_with_retire: got %b expected 1", tag, bus.pc_we); end
            end
        end
        checks++; if (!done) begin errors++; $display("FAIL %s retire: no pulse within 40 cycles", tag); end
        checks++; if (cyc != ecyc) begin errors++; $display("FAIL %s cycles: got %0d expected %0d", tag, cyc, ecyc); end
        checks++; if (got_op !== eop) begin errors++; $display("FAIL %s alu_op: got %b expected %b", tag, got_op, eop); end
        checks++; if (got_pc !== 1'(epc)) begin errors++; $display("FAIL %s pc_sel: got %b expected %0d", tag, got_pc, epc); end
        checks++; if (nrfwe != ewr) begin errors++; $display("FAIL %s rf_we_cycles: got %0d expected %0d", tag, nrfwe, ewr); end
        if (ewr) begin
            checks++; if (got_wb !== 2'(ewb)) begin errors++; $display("FAIL %s wb_sel: got %b expected %0d", tag, got_wb, ewb); end
        end
        checks++; if (got_a !== 1'(ea) || got_b !== 2'(eb)) begin errors++; $display("FAIL %s exec_sel: got a=%b b=%b expected a=%0d b=%0d", tag, got_a, got_b, ea, eb); end
        checks++; if (nirwe != 1) begin errors++; $display("FAIL %s ir_we_cycles: got %0d expected 1", tag, nirwe); end
        checks++; if (nireq != idel + 1) begin errors++; $display("FAIL %s imem_req_cycles: got %0d expected %0d", tag, nireq, idel + 1); end
        checks++; if (ndreq != edreq || ndwe != edwe) begin errors++; $display("FAIL %s dmem: got req=%0d we=%0d expected req=%0d we=%0d", tag, ndreq, ndwe, edreq, edwe); end
        checks++; if (bus.illegal !== 1'b0 || bus.timeout !== 1'b0) begin errors++; $display("FAIL %s flags: got illegal=%b timeout=%b expected 0/0", tag, bus.illegal, bus.timeout); end
    endtask

    task automatic test_reset();
        logic [24:0] outs;
        rst_n = 1'b0;
        bus.instr = '0; bus.imem_ack = 1'b0; bus.dmem_ack = 1'b0; bus.alu_zero = 1'b0; bus.alu_lt = 1'b0;
        repeat (3) @(negedge clk);
        outs = {bus.imem_req, bus.dmem_req, bus.dmem_we, bus.ir_we, bus.pc_we, bus.pc_sel, bus.alu_op,
                bus.alu_a_sel, bus.alu_b_sel, bus.imm_sel, bus.rf_we, bus.wb_sel, bus.retire,
                bus.illegal, bus.timeout, bus.state};
        checks++; if (outs !== '0) begin errors++; $display("FAIL reset_outputs: got %h expected 0", outs); end
        rst_n = 1'b1;
        #1;
        checks++; if (bus.state !== 3'd0 || bus.imem_req !== 1'b0) begin errors++; $display("FAIL reset_idle: got state=%0d imem_req=%b expected 0/0", bus.state, bus.imem_req); end
    endtask

    task automatic test_add();
        run_instr(32'h002081B3, 0, 0, 1'b0, 1'b0, "add");
    endtask

    task automatic test_branch();
        run_instr(32'h00208063, 0, 0, 1'b1, 1'b0, "beq_taken");
        run_instr(32'h00208063, 0, 0, 1'b0, 1'b1, "beq_not_taken");
        run_instr(32'h0020C063, 0, 0, 1'b0, 1'b1, "blt_taken");
        run_instr(32'h0020C063, 0, 0, 1'b1, 1'b0, "blt_not_taken");
    endtask

    task automatic test_mem_waits();
        run_instr(32'h0080A283, 0, 3, 1'b0, 1'b0, "lw_wait3");
        run_instr(32'h0020A223, 1, 3, 1'b0, 1'b0, "sw_wait3");
        run_instr(32'h00500013, 0, 0, 1'b0, 1'b0, "addi_x0");
        run_instr(32'h000000EF, 3, 0, 1'b0, 1'b0, "jal_ack_last");
    endtask

    task automatic test_back_to_back();
        for (int i = 0; i < 40; i++)
            run_instr(gen_instr($urandom_range(0, 6)), $urandom_range(0, 3), $urandom_range(0, 3),
                      1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), $sformatf("rand%0d", i));
    endtask

    task automatic test_illegal();
        logic [31:0] bad [4];
        int kind, nireq, nret;
        logic [5:0] op;
        bad = '{32'hFFFFFFFF, 32'h4020D1B3, 32'h00008103, 32'h0000A013};
        for (int i = 0; i < 4; i++) begin
            ref_decode(bad[i], kind, op);
            do_reset();
            bus.instr = bad[i];
            iw = 0; dw = 0; nireq = 0; nret = 0;
            for (int n = 0; n < 25; n++) begin
                drive_cycle(0, 0, 1'b0, 1'b0, 1'b1);
                if (bus.imem_req) nireq++;
                if (bus.retire)   nret++;
            end
            checks++; if (bus.illegal !== 1'(kind < 0)) begin errors++; $display("FAIL illegal%0d flag: got %b expected %0d", i, bus.illegal, kind < 0); end
            checks++; if (nireq != 1 || nret != 0 || bus.timeout !== 1'b0) begin errors++; $display("FAIL illegal%0d trap: got req=%0d retire=%0d timeout=%b expected 1/0/0", i, nireq, nret, bus.timeout); end
        end
        rst_n = 1'b0;
        #1;
        checks++; if (bus.illegal !== 1'b0) begin errors++; $display("FAIL illegal_clear: got %b expected 0", bus.illegal); end
    endtask

    task automatic test_timeout();
        int nireq, ndreq, nret;
        do_reset();
        bus.instr = 32'h002081B3;
        iw = 0; dw = 0; nireq = 0;
        for (int n = 0; n < 15; n++) begin
            drive_cycle(-1, -1, 1'b0, 1'b0, 1'b0);
            if (bus.imem_req) nireq++;
        end
        checks++; if (nireq != 4) begin errors++; $display("FAIL itimeout_req: got %0d expected 4", nireq); end
        checks++; if (bus.timeout !== 1'b1 || bus.illegal !== 1'b0) begin errors++; $display("FAIL itimeout_flag: got timeout=%b illegal=%b expected 1/0", bus.timeout, bus.illegal); end
        do_reset();
        bus.instr = 32'h0080A283;
        iw = 0; dw = 0; nireq = 0; ndreq = 0; nret = 0;
        for (int n = 0; n < 20; n++) begin
            drive_cycle(0, -1, 1'b0, 1'b0, 1'b1);
            if (bus.imem_req) nireq++;
            if (bus.dmem_req) ndreq++;
            if (bus.retire)   nret++;
        end
        checks++; if (ndreq != 4 || nireq != 1 || nret != 0) begin errors++; $display("FAIL dtimeout_req: got dreq=%0d ireq=%0d retire=%0d expected 4/1/0", ndreq, nireq, nret); end
        checks++; if (bus.timeout !== 1'b1) begin errors++; $display("FAIL dtimeout_flag: got %b expected 1", bus.timeout); end
    endtask

    task automatic test_reset_mid_sw();
        bit found;
        do_reset();
        bus.instr = 32'h0020A223;
        iw = 0; dw = 0; found = 0;
        for (int n = 0; n < 12 && !found; n++) begin
            drive_cycle(0, -1, 1'b0, 1'b0, 1'b1);
            if (bus.dmem_req) found = 1;
        end
        checks++; if (!found) begin errors++; $display("FAIL sw_reach_mem: dmem_req not seen within 12 cycles"); end
        drive_cycle(0, -1, 1'b0, 1'b0, 1'b1);
        #2;
        rst_n = 1'b0;
        #1;
        checks++; if (bus.dmem_req !== 1'b0 || bus.retire !== 1'b0 || bus.pc_we !== 1'b0 || bus.state !== 3'd0) begin
            errors++; $display("FAIL sw_abort: got dreq=%b retire=%b pc_we=%b state=%0d expected 0/0/0/0", bus.dmem_req, bus.retire, bus.pc_we, bus.state);
        end
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        checks++; if (bus.imem_req !== 1'b0) begin errors++; $display("FAIL restart_idle: got imem_req=%b expected 0", bus.imem_req); end
        iw = 0; dw = 0;
        drive_cycle(0, 0, 1'b0, 1'b0, 1'b0);
        checks++; if (bus.imem_req !== 1'b1) begin errors++; $display("FAIL restart_fetch: got imem_req=%b expected 1", bus.imem_req); end
    endtask

    initial begin
        test_reset();
        test_add();
        test_branch();
        test_mem_waits();
        test_back_to_back();
        test_illegal();
        test_timeout();
        test_reset_mid_sw();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
